kgd_scanout: RTL and testbench
==============================

Name: kgd_scanout

Overview:
- Scan-out stage directly downstream of the KGD dual-port video RAM.
- Drives the 17-bit bit-address of kgdvram port B and consumes its 1-bit read data.
- Emits a 1-bit pixel stream, with optional horizontal and vertical pixel doubling and hardware vertical scroll, to the VGA output mixer.
- Raster timing (hsync/vsync) is generated elsewhere. This block follows frame_start, line_start and pix_en strobes.

Parameters:
H_PIX, 400, KGD pixels per line (bits per row in VRAM)
V_LINES, 286, KGD rows per frame
HSCALE, 2, output pixels per KGD pixel (1 or 2)
VSCALE, 2, output lines per KGD row (1 or 2)

Ports:
clock  in  1  system clock, same clock as kgdvram clock_b
reset  in  1  synchronous, active-high reset
frame_start  in  1  one-clock pulse, start of the first visible output line of a frame
line_start  in  1  one-clock pulse, start of the visible part of each output line
pix_en  in  1  output-pixel clock enable; at most one per 2 clocks
kgd_on  in  1  graphics enable; 0 forces pixel low
scroll  in  9  first KGD row displayed (0..V_LINES-1); sampled at frame_start
vram_addr  out  17  bit address to kgdvram address_b
vram_q  in  1  kgdvram q_b (1-clock read latency)
pixel  out  1  output pixel
pixel_valid  out  1  high while pixel belongs to the active KGD area
frame_done  out  1  one-clock pulse after the last pixel of the last row

Behaviour:
- Clock and reset: single clock domain named clock. Synchronous active-high reset named reset.
- Reset values: state=IDLE, vram_addr=0, pixel=0, pixel_valid=0, frame_done=0, all counters 0.
- States: IDLE, WAIT_LINE, ACTIVE, FLUSH.
- IDLE:
  - frame_start -> latch row = scroll (values >= V_LINES are clamped to 0), row_base = row*H_PIX.
  - The multiply is built as a sequential add over at most V_LINES-1 cycles in the background. It must finish before the first line_start; frame_start precedes line_start by >= 512 clocks.
  - vcnt=0, then -> WAIT_LINE.
- WAIT_LINE:
  - line_start -> col=0, hsub=0, vram_addr=row_base, then -> ACTIVE.
  - frame_start here restarts the frame exactly as from IDLE.
- ACTIVE, on each pix_en:
  - pixel <= vram_q (data for the address presented at the previous pix_en); pixel_valid <= 1.
  - hsub advances mod HSCALE. When hsub wraps, col increments and vram_addr increments.
  - After col reaches H_PIX-1 and its last sub-pixel is issued -> FLUSH.
- FLUSH, on the next pix_en:
  - Last pixel is output, then pixel_valid <= 0.
  - vsub advances mod VSCALE. When vsub wraps, row increments and row_base += H_PIX.
  - Row wrap: if row reaches V_LINES, row=0 and row_base=0. This is the scroll wrap-around.
  - vcnt counts completed KGD rows. When vcnt == V_LINES and vsub wrapped: frame_done pulses for one clock, then -> IDLE. Otherwise -> WAIT_LINE.
- Latency: pixel for KGD column c appears one pix_en after its address is driven.
  - The first pix_en in ACTIVE outputs pixel_valid=1 with the column-0 value, because the address was set at line_start.
  - Output per line is exactly H_PIX*HSCALE valid pixels.
- Gating: pixel = registered data AND kgd_on AND pixel_valid. kgd_on has no effect on addressing.
- Outside ACTIVE/FLUSH: pixel=0, pixel_valid=0.
- Address range: vram_addr never exceeds H_PIX*V_LINES-1; no 17-bit overflow.
- Missing line_start mid-line: line_start while ACTIVE aborts the current line and restarts the same output line at col 0; vsub does not advance.
- Simultaneous events: frame_start and line_start in the same clock means frame_start is processed first and line_start is ignored. Reset overrides everything.
- Reset mid-frame returns to IDLE next clock with outputs low. No frame_done is issued.
- Scroll changes take effect only at the next frame_start.

Test Plan:
- Reset, then frame_start with scroll=0, VSCALE=HSCALE=2, VRAM preloaded with bit n = n[0] -> first output line reads 0,0,1,1,0,0,...; 800 valid pixels; second output line identical (row repeated); third output line starts at vram_addr=400.
- Full frame with scroll=0 -> frame_done pulses once after 572 lines; the max vram_addr seen is 114399.
- scroll=285 -> first row address 114000; next KGD row address 0 (wrap); 286 distinct rows are displayed.
- kgd_on=0 during line 10 -> pixel stays 0 while pixel_valid and vram_addr sequence are unchanged.
- line_start reasserted at col 150 -> vram_addr returns to row_base; the line yields a fresh 800 valid pixels; the following row counts are unchanged.
- reset asserted at row 100 col 37 -> next clock pixel_valid=0, vram_addr=0, state IDLE; the next frame_start begins cleanly at row=scroll.

Source files
------------

// File: rtl/kgd_scanout_if.sv
// kgd_scanout_if: the signals between the KGD scan-out stage and its
// environment.
//   frame_start  raster strobe: first visible output line of a frame
//   line_start   raster strobe: start of the visible part of a line
//   pix_en       output-pixel clock enable
//   kgd_on       graphics enable; when low the pixel is forced low
//   scroll       first KGD row displayed, taken at frame_start
//   vram_addr    bit address to kgdvram port B
//   vram_q       kgdvram port B read data (1-clock latency)
//   pixel        output pixel to the VGA mixer
//   pixel_valid  pixel belongs to the active KGD area
//   frame_done   one-clock pulse after the last pixel of a frame
// The master modport is the environment (raster timing, VRAM, mixer).
// The slave modport is the scan-out block.
interface kgd_scanout_if;
  logic        frame_start;
  logic        line_start;
  logic        pix_en;
  logic        kgd_on;
  logic [8:0]  scroll;
  logic [16:0] vram_addr;
  logic        vram_q;
  logic        pixel;
  logic        pixel_valid;
  logic        frame_done;

  modport master (
    output frame_start, line_start, pix_en, kgd_on, scroll, vram_q,
    input  vram_addr, pixel, pixel_valid, frame_done
  );

  modport slave (
    input  frame_start, line_start, pix_en, kgd_on, scroll, vram_q,
    output vram_addr, pixel, pixel_valid, frame_done
  );
endinterface

// File: rtl/kgd_scanout.sv
// kgd_scanout: reads the KGD 1-bit frame buffer through kgdvram port B and
// produces a pixel stream with optional horizontal/vertical pixel doubling
// and a hardware vertical scroll with wrap-around.
// Ports:
//   clock  system clock (also kgdvram clock_b)
//   reset  synchronous, active-high
//   bus    kgd_scanout_if.slave (raster strobes, VRAM port B, pixel out)
//
// state     | meaning
// IDLE      | no frame in progress, waiting for frame_start
// WAIT_LINE | frame running, waiting for the next line_start
// ACTIVE    | emitting pixels of one output line on pix_en
// FLUSH     | last pixel on screen; next pix_en closes the line
module kgd_scanout #(
  parameter int H_PIX   = 400,
  parameter int V_LINES = 286,
  parameter int HSCALE  = 2,
  parameter int VSCALE  = 2
) (
  input  logic         clock,
  input  logic         reset,
  kgd_scanout_if.slave bus
);

  localparam int AW    = 17;
  localparam int COL_W = (H_PIX > 1) ? $clog2(H_PIX) : 1;
  localparam int ROW_W = $clog2(V_LINES + 1);
  localparam int HS_W  = (HSCALE > 1) ? $clog2(HSCALE) : 1;
  localparam int VS_W  = (VSCALE > 1) ? $clog2(VSCALE) : 1;

  localparam logic [AW-1:0]    H_STEP   = AW'(H_PIX);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(H_PIX - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(V_LINES - 1);
  localparam logic [HS_W-1:0]  HS_LAST  = HS_W'(HSCALE - 1);
  localparam logic [VS_W-1:0]  VS_LAST  = VS_W'(VSCALE - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_LINE,
    ACTIVE,
    FLUSH
  } state_t;

  state_t           r_state;
  logic [ROW_W-1:0] r_row;
  logic [AW-1:0]    r_row_base;
  logic [ROW_W-1:0] r_mul_cnt;
  logic [ROW_W-1:0] r_vcnt;
  logic [COL_W-1:0] r_col;
  logic [HS_W-1:0]  r_hsub;
  logic [VS_W-1:0]  r_vsub;
  logic [AW-1:0]    r_addr;
  logic             r_data;
  logic             r_valid;
  logic             r_done;

  logic [ROW_W-1:0] w_scroll_row;
  logic             w_hsub_last;
  logic             w_vsub_last;
  logic             w_col_last;
  logic             w_row_last;
  logic             w_vcnt_last;

  // Out-of-range scroll values fall back to the top of the buffer.
  assign w_scroll_row = (int'(bus.scroll) < V_LINES) ? ROW_W'(bus.scroll) : '0;
  assign w_hsub_last  = (r_hsub == HS_LAST);
  assign w_vsub_last  = (r_vsub == VS_LAST);
  assign w_col_last   = (r_col == COL_LAST);
  assign w_row_last   = (r_row == ROW_LAST);
  // vcnt holds completed rows; this row completing makes V_LINES.
  assign w_vcnt_last  = (r_vcnt == ROW_LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= IDLE;
      r_row      <= '0;
      r_row_base <= '0;
      r_mul_cnt  <= '0;
      r_vcnt     <= '0;
      r_col      <= '0;
      r_hsub     <= '0;
      r_vsub     <= '0;
      r_addr     <= '0;
      r_data     <= 1'b0;
      r_valid    <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;

      // row_base = row * H_PIX built by repeated addition; r_mul_cnt is
      // loaded with the row at frame_start and counts down to zero. The
      // raster guarantees this completes before the first line_start.
      if (r_mul_cnt != '0) begin
        r_row_base <= r_row_base + H_STEP;
        r_mul_cnt  <= r_mul_cnt - ROW_W'(1);
      end

      // frame_start restarts the frame from any state and wins over a
      // coincident line_start.
      if (bus.frame_start) begin
        r_row      <= w_scroll_row;
        r_row_base <= '0;
        r_mul_cnt  <= w_scroll_row;
        r_vcnt     <= '0;
        r_vsub     <= '0;
        r_hsub     <= '0;
        r_col      <= '0;
        r_data     <= 1'b0;
        r_valid    <= 1'b0;
        r_state    <= WAIT_LINE;
      end else begin
        case (r_state)
          IDLE: begin
            r_valid <= 1'b0;
          end

          WAIT_LINE: begin
            if (bus.line_start) begin
              r_col   <= '0;
              r_hsub  <= '0;
              r_addr  <= r_row_base;
              r_state <= ACTIVE;
            end
          end

          ACTIVE: begin
            if (bus.line_start) begin
              // Raster restarted the line: replay the same output line.
              r_col   <= '0;
              r_hsub  <= '0;
              r_addr  <= r_row_base;
              r_valid <= 1'b0;
              r_data  <= 1'b0;
            end else if (bus.pix_en) begin
              r_data  <= bus.vram_q;
              r_valid <= 1'b1;
              if (w_hsub_last) begin
                r_hsub <= '0;
                if (w_col_last) begin
                  r_state <= FLUSH;
                end else begin
                  r_col  <= r_col + COL_W'(1);
                  r_addr <= r_addr + AW'(1);
                end
              end else begin
                r_hsub <= r_hsub + HS_W'(1);
              end
            end
          end

          FLUSH: begin
            if (bus.line_start) begin
              r_col   <= '0;
              r_hsub  <= '0;
              r_addr  <= r_row_base;
              r_valid <= 1'b0;
              r_data  <= 1'b0;
              r_state <= ACTIVE;
            end else if (bus.pix_en) begin
              r_valid <= 1'b0;
              r_data  <= 1'b0;
              r_state <= WAIT_LINE;
              if (w_vsub_last) begin
                r_vsub <= '0;
                r_vcnt <= r_vcnt + ROW_W'(1);
                if (w_row_last) begin
                  r_row      <= '0;
                  r_row_base <= '0;
                end else begin
                  r_row      <= r_row + ROW_W'(1);
                  r_row_base <= r_row_base + H_STEP;
                end
                if (w_vcnt_last) begin
                  r_done  <= 1'b1;
                  r_state <= IDLE;
                end
              end else begin
                r_vsub <= r_vsub + VS_W'(1);
              end
            end
          end

          default: begin
            r_state <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.vram_addr   = r_addr;
  assign bus.pixel       = r_data & bus.kgd_on & r_valid;
  assign bus.pixel_valid = r_valid;
  assign bus.frame_done  = r_done;

endmodule

// File: tb/tb_kgd_scanout.sv
// Scoreboard bench for kgd_scanout, run at a reduced raster size so that
// several complete frames fit in a short simulation.
module tb_kgd_scanout;
  localparam int H   = 24;
  localparam int V   = 10;
  localparam int HS  = 2;
  localparam int VS  = 2;
  localparam int LPF = V * VS;

  logic clock = 1'b0;
  logic reset;

  kgd_scanout_if ifc ();

  kgd_scanout #(.H_PIX(H), .V_LINES(V), .HSCALE(HS), .VSCALE(VS)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (ifc.slave)
  );

  always #5 clock = ~clock;

  bit mem [H*V];

  always @(posedge clock)
    ifc.vram_q <= (int'(ifc.vram_addr) < H*V) ? mem[int'(ifc.vram_addr)] : 1'b0;

  int n_checks = 0;
  int n_errors = 0;
  bit exp_q [$];
  bit mon_e;
  int m_first_row;
  int m_line;
  int max_addr = 0;
  int n_done_pulses = 0;
  int exp_done = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: a pixel is consumed at every pix_en while pixel_valid is high.
  always @(negedge clock) begin
    if (!reset && ifc.pix_en && ifc.pixel_valid) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL sb_underflow: pixel=%0b with nothing expected", ifc.pixel);
      end else begin
        mon_e = exp_q.pop_front();
        if (ifc.pixel !== mon_e) begin
          n_errors++;
          $display("FAIL pixel: got %0b expected %0b (line %0d)", ifc.pixel, mon_e, m_line);
        end
      end
    end
    if (ifc.frame_done === 1'b1) n_done_pulses++;
    if (!reset && int'(ifc.vram_addr) > max_addr) max_addr = int'(ifc.vram_addr);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pix_pulse();
    ifc.pix_en = 1'b1;
    tick();
    ifc.pix_en = 1'b0;
    repeat ($urandom_range(1, 2)) tick();
  endtask

  // Reference: output line L of a frame shows KGD row
  // (first_row + L/VS) mod V, each column repeated HS times.
  function automatic int row_base_of(input int line);
    return ((m_first_row + line / VS) % V) * H;
  endfunction

  task automatic push_line(input int rb, input bit kon, input int count);
    for (int k = 0; k < count; k++)
      exp_q.push_back(mem[rb + k / HS] & kon);
  endtask

  task automatic start_line(input int rb, input string name);
    ifc.line_start = 1'b1;
    tick();
    ifc.line_start = 1'b0;
    @(negedge clock);
    check(name, ifc.vram_addr, rb);
    check("line_start_valid", ifc.pixel_valid, 0);
    @(posedge clock);
    #1;
  endtask

  task automatic start_frame(input int s);
    ifc.scroll      = 9'(s);
    ifc.frame_start = 1'b1;
    tick();
    ifc.frame_start = 1'b0;
    ifc.scroll      = 9'($urandom_range(0, 511));
    m_first_row     = (s < V) ? s : 0;
    m_line          = 0;
    repeat (520) tick();
  endtask

  task automatic run_line(input bit kon, input int abort_n);
    int rb;
    bit last;
    rb   = row_base_of(m_line);
    last = (m_line == LPF - 1);
    ifc.kgd_on = kon;
    if (abort_n > 0) begin
      push_line(rb, kon, abort_n - 1);
      start_line(rb, "line_addr");
      repeat (abort_n) pix_pulse();
      start_line(rb, "abort_addr");
    end else begin
      start_line(rb, "line_addr");
    end
    push_line(rb, kon, H * HS);
    repeat (H * HS) pix_pulse();
    ifc.pix_en = 1'b1;
    tick();
    ifc.pix_en = 1'b0;
    check("frame_done", ifc.frame_done, last);
    check("flush_valid", ifc.pixel_valid, 0);
    tick();
    if (last) begin
      check("done_width", ifc.frame_done, 0);
      exp_done++;
    end
    m_line++;
    repeat (3) tick();
  endtask

  task automatic reset_mid_line(input int n);
    int rb;
    rb = row_base_of(m_line);
    ifc.kgd_on = 1'b1;
    push_line(rb, 1'b1, n - 1);
    start_line(rb, "line_addr");
    repeat (n) pix_pulse();
    reset = 1'b1;
    tick();
    check("rst_valid", ifc.pixel_valid, 0);
    check("rst_addr", ifc.vram_addr, 0);
    check("rst_pixel", ifc.pixel, 0);
    check("rst_done", ifc.frame_done, 0);
    reset = 1'b0;
    tick();
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset           = 1'b1;
    ifc.frame_start = 1'b0;
    ifc.line_start  = 1'b0;
    ifc.pix_en      = 1'b0;
    ifc.kgd_on      = 1'b0;
    ifc.scroll      = '0;
    repeat (3) tick();
    check("reset_valid", ifc.pixel_valid, 0);
    check("reset_pixel", ifc.pixel, 0);
    check("reset_addr", ifc.vram_addr, 0);
    check("reset_done", ifc.frame_done, 0);
    reset = 1'b0;
    tick();

    // Alternating bit pattern, scroll 0, graphics off on line 10.
    for (int n = 0; n < H * V; n++) mem[n] = n[0];
    start_frame(0);
    max_addr = 0;
    for (int l = 0; l < LPF; l++) run_line(l != 10, 0);
    check("max_addr", max_addr, H * V - 1);

    // Random image, scroll at the last row (wraps), one restarted line.
    for (int n = 0; n < H * V; n++) mem[n] = 1'($urandom_range(0, 1));
    start_frame(V - 1);
    for (int l = 0; l < LPF; l++) run_line(1'b1, (l == 5) ? 7 * HS : 0);

    // Out-of-range scroll clamps to row 0; frame restarted part way.
    start_frame(300);
    repeat (4) run_line(1'($urandom_range(0, 1)), 0);
    start_frame($urandom_range(0, V - 1));
    for (int l = 0; l < LPF; l++) run_line(1'($urandom_range(0, 1)), 0);

    // Reset in the middle of a line, then IDLE must ignore line_start.
    start_frame(3);
    repeat (5) run_line(1'b1, 0);
    reset_mid_line(5 * HS + 1);
    ifc.line_start = 1'b1;
    tick();
    ifc.line_start = 1'b0;
    repeat (4) pix_pulse();
    check("idle_valid", ifc.pixel_valid, 0);
    check("idle_addr", ifc.vram_addr, 0);

    // Clean frame after the reset.
    start_frame(6);
    for (int l = 0; l < LPF; l++) run_line(1'b1, 0);

    repeat (5) tick();
    check("sb_empty", exp_q.size(), 0);
    check("frame_done_count", n_done_pulses, exp_done);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
